mdu_e: RTL and testbench

Multiply/divide unit for the E stage of the pipelined MIPS core. It consumes the forwarded register-file read operands, either the E-stage copies of the register read ports or their bypassed values. It executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and holds the HI/LO architectural registers. It serves MFHI/MFLO reads and MTHI/MTLO writes, and drives `busy` to the hazard unit so that dependent MDU instructions stall in D.

---
 rtl/mdu_e.sv | 142 ++++++++++++++
 tb/tb_mdu_e.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_e.sv
// mdu_e: E-stage multiply/divide unit. Holds the HI/LO architectural
// registers, runs MULT/MULTU/DIV/DIVU with a fixed busy latency, and serves
// MTHI/MTLO writes and MFHI/MFLO reads. The 64-bit result is computed when
// the op is accepted and parked in temporaries until the busy window expires.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mf_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count;
  logic [31:0]     tmp_hi, tmp_lo;
  logic            tmp_valid;

  logic            accept, arith_start, commit;

  logic [63:0]     a_sx, b_sx, prod_s, prod_u;
  logic [31:0]     a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [63:0]     result;
  logic            div_by_zero;

  // A start only counts when the pipeline did not flush it and the unit is idle.
  assign accept      = start & ~req & ~busy;
  assign arith_start = accept & ~mdu_op[2];
  assign commit      = (state == RUN) && (count == CNT_ONE);
  assign stall_md    = busy | (start & ~req & ~mdu_op[2]);

  // MFHI/MFLO read path straight off the architectural registers.
  always_comb begin
    mf_out = 32'd0;
    if (mdu_op == 3'd6) mf_out = HI;
    else if (mdu_op == 3'd7) mf_out = LO;
  end

  // Operand arithmetic; signed divide works on magnitudes so that the
  // 0x80000000 / -1 case wraps cleanly to 0x80000000 with zero remainder.
  always_comb begin
    a_sx   = {{32{A[31]}}, A};
    b_sx   = {{32{B[31]}}, B};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, A} * {32'd0, B};

    a_mag  = A[31] ? (~A + 32'd1) : A;
    b_mag  = B[31] ? (~B + 32'd1) : B;
    q_mag  = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    r_mag  = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    q_s    = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s    = A[31] ? (~r_mag + 32'd1) : r_mag;
    q_u    = (B == 32'd0) ? 32'd0 : (A / B);
    r_u    = (B == 32'd0) ? 32'd0 : (A % B);

    div_by_zero = mdu_op[1] & (B == 32'd0);

    case (mdu_op[1:0])
      2'd0:    result = prod_s;
      2'd1:    result = prod_u;
      2'd2:    result = {r_s, q_s};
      default: result = {r_u, q_u};
    endcase
  end

  // State register for the IDLE/RUN sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: leave IDLE on an accepted arithmetic op, leave RUN on the last count.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arith_start) state_next = RUN;
      RUN:     if (commit)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Busy is simply being in RUN.
  always_comb begin
    busy = (state == RUN);
  end

  // Latency counter: loaded on start, counts down to the commit edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (arith_start) begin
      count <= mdu_op[1] ? DIV_LOAD : MULT_LOAD;
    end else if (state == RUN) begin
      count <= count - CNT_ONE;
    end
  end

  // Result temporaries and HI/LO: MTHI/MTLO write immediately, arithmetic
  // results land at the commit edge unless the divisor was zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmp_hi    <= '0;
      tmp_lo    <= '0;
      tmp_valid <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else begin
      if (arith_start) begin
        tmp_hi    <= result[63:32];
        tmp_lo    <= result[31:0];
        tmp_valid <= ~div_by_zero;
      end
      if (accept && mdu_op == 3'd4) HI <= A;
      if (accept && mdu_op == 3'd5) LO <= A;
      if (commit && tmp_valid) begin
        HI <= tmp_hi;
        LO <= tmp_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_e.sv
// tb_mdu_e: directed and randomized checks of mdu_e against a cycle-level
// arithmetic model (64-bit integer math, remaining-cycles counter).
module tb_mdu_e;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] a_val;
  logic [31:0] b_val;
  logic        req;
  logic        busy;
  logic        stall_md;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] mf_out;

  int total;
  int bad;

  int          m_left;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_ok;

  mdu_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mdu_op   (mdu_op),
    .A        (a_val),
    .B        (b_val),
    .req      (req),
    .busy     (busy),
    .stall_md (stall_md),
    .HI       (HI),
    .LO       (LO),
    .mf_out   (mf_out)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference arithmetic in plain 64-bit integers.
  function automatic void modelCompute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] hi, output logic [31:0] lo, output bit ok);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    logic [63:0]     bits;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ok = 1'b1;
    bits = '0;
    case (op)
      3'd0: bits = sa * sb;
      3'd1: begin p = ua * ub; bits = p; end
      3'd2: begin
        if (b == 32'd0) ok = 1'b0;
        else begin q = sa / sb; r = sa % sb; bits = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (b == 32'd0) ok = 1'b0;
        else begin p = ua / ub; bits[31:0] = p[31:0]; p = ua % ub; bits[63:32] = p[31:0]; end
      end
    endcase
    hi = bits[63:32];
    lo = bits[31:0];
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: drive inputs, check combinational outputs, advance the
  // model across the rising edge, then check registered outputs.
  task automatic applyStimulus(input bit st, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit rq);
    logic [31:0] exp_mf;
    bit          exp_stall;
    start = st; mdu_op = op; a_val = a; b_val = b; req = rq;
    #1;
    exp_stall = (m_left > 0) || (st && !rq && op < 3'd4);
    exp_mf = (op == 3'd6) ? m_hi : (op == 3'd7) ? m_lo : 32'd0;
    checkOutput("stall_md", 32'(stall_md), 32'(exp_stall));
    checkOutput("mf_out", mf_out, exp_mf);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_ok) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (st && !rq) begin
      if (op < 3'd4) begin
        modelCompute(op, a, b, p_hi, p_lo, p_ok);
        m_left = (op >= 3'd2) ? DC : MC;
      end else if (op == 3'd4) m_hi = a;
      else if (op == 3'd5) m_lo = a;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    req = 1'b0;
    checkOutput("busy", 32'(busy), (m_left > 0) ? 32'd1 : 32'd0);
    checkOutput("HI", HI, m_hi);
    checkOutput("LO", LO, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'(6 + (i % 2)), 32'd0, 32'd0, 1'b0);
  endtask

  task automatic modelClear();
    m_left = 0; m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_ok = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    clk = 1'b0; reset = 1'b0; start = 1'b0; mdu_op = '0;
    a_val = '0; b_val = '0; req = 1'b0;
    modelClear();

    // Reset state.
    #12;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_hi", HI, 32'd0);
    checkOutput("rst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // MULT / MULTU of -1 and 2.
    applyStimulus(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(MC);
    checkOutput("mult_hi", HI, 32'hFFFF_FFFF);
    checkOutput("mult_lo", LO, 32'hFFFF_FFFE);
    applyStimulus(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(MC);
    checkOutput("multu_hi", HI, 32'h0000_0001);
    checkOutput("multu_lo", LO, 32'hFFFF_FFFE);

    // DIV -7/2 and DIVU 7/2.
    applyStimulus(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(DC);
    checkOutput("div_lo", LO, 32'hFFFF_FFFD);
    checkOutput("div_hi", HI, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 3'd3, 32'd7, 32'd2, 1'b0);
    idle(DC);
    checkOutput("divu_lo", LO, 32'd3);
    checkOutput("divu_hi", HI, 32'd1);

    // Signed overflow divide.
    applyStimulus(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DC);
    checkOutput("ovf_lo", LO, 32'h8000_0000);
    checkOutput("ovf_hi", HI, 32'd0);

    // MTHI/MTLO then divide by zero leaves HI/LO alone.
    applyStimulus(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0);
    applyStimulus(1'b1, 3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0);
    applyStimulus(1'b1, 3'd3, 32'd99, 32'd0, 1'b0);
    idle(DC);
    applyStimulus(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    checkOutput("dz_hi", HI, 32'h1234_5678);
    checkOutput("dz_lo", LO, 32'h9ABC_DEF0);

    // Flushed MULT, then MULT issued under a running DIV.
    applyStimulus(1'b1, 3'd0, 32'd3, 32'd3, 1'b1);
    checkOutput("req_busy", 32'(busy), 32'd0);
    applyStimulus(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    applyStimulus(1'b1, 3'd0, 32'd5, 32'd5, 1'b0);
    idle(DC - 1);
    checkOutput("ovl_lo", LO, 32'd14);
    checkOutput("ovl_hi", HI, 32'd2);

    // Asynchronous reset in the third cycle of a DIV.
    applyStimulus(1'b1, 3'd2, 32'd1000, 32'd3, 1'b0);
    idle(2);
    #2;
    reset = 1'b0;
    #1;
    modelClear();
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_hi", HI, 32'd0);
    checkOutput("arst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(DC + 1);
    checkOutput("arst_hold_hi", HI, 32'd0);

    // Start at T0+MC is rejected, at T0+MC+1 accepted.
    applyStimulus(1'b1, 3'd0, 32'd6, 32'd7, 1'b0);
    idle(MC - 1);
    applyStimulus(1'b1, 3'd1, 32'd9, 32'd9, 1'b0);
    checkOutput("b2b_reject", 32'(busy), 32'd0);
    applyStimulus(1'b1, 3'd1, 32'd9, 32'd9, 1'b0);
    checkOutput("b2b_accept", 32'(busy), 32'd1);
    idle(MC);
    checkOutput("b2b_lo", LO, 32'd81);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    randOperand(), randOperand(), ($urandom_range(0, 9) == 0));
    end
    idle(DC + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
